// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice and one carry flop, one bit per clock, LSB first.
// Returns sum/difference with carry-out and signed overflow under a start/busy/done handshake.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             M,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Cout,
   output logic             V
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_aSr;
   logic [WIDTH-1:0] r_bSr;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_d;
   logic             r_cout;
   logic             r_v;

   logic w_accept;
   logic w_lastBit;
   logic w_sum;
   logic w_carry;

   assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_lastBit = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
   assign w_sum     = r_aSr[0] ^ r_bSr[0] ^ r_c;
   assign w_carry   = (r_aSr[0] & r_bSr[0]) | (r_c & (r_aSr[0] ^ r_bSr[0]));

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = RUN;
         RUN:     if (w_lastBit) w_next = DONE;
         DONE:    w_next = w_accept ? RUN : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // busy/done are decoded from the next state so they come straight out of flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == RUN);
         r_done  <= (w_next == DONE);
      end
   end

   // The sum bits are shifted into the MSB end of the A shift register as its bits are consumed,
   // so after WIDTH cycles that register holds the result without a separate accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_aSr  <= '0;
         r_bSr  <= '0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         r_d    <= '0;
         r_cout <= 1'b0;
         r_v    <= 1'b0;
      end else if (w_accept) begin
         r_aSr <= A;
         r_bSr <= B ^ {WIDTH{M}};
         r_c   <= M;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_aSr <= {w_sum, r_aSr[WIDTH-1:1]};
         r_bSr <= {1'b0, r_bSr[WIDTH-1:1]};
         r_c   <= w_carry;
         r_cnt <= r_cnt + CW'(1);
         if (w_lastBit) begin
            r_d    <= {w_sum, r_aSr[WIDTH-1:1]};
            r_cout <= w_carry;
            r_v    <= r_c ^ w_carry;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign D    = r_d;
   assign Cout = r_cout;
   assign V    = r_v;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: an 8-bit instance with directed and swept vectors,
// and a 2-bit instance swept exhaustively, each checked by its own monitor.
module tb_serial_addsub;

   typedef struct {
      logic [31:0] d;
      logic        c;
      logic        v;
      int          acceptEdge;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle++;

   int nAssert = 0;
   int nFail   = 0;
   bit u2Finished = 1'b0;

   exp_t q8[$];
   exp_t q2[$];

   logic       rst, start, M, busy, done, Cout, V;
   logic [7:0] A, B, D;

   logic       rst2, start2, M2, busy2, done2, Cout2, V2;
   logic [1:0] A2, B2, D2;

   serial_addsub #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start), .M(M), .A(A), .B(B),
      .busy(busy), .done(done), .D(D), .Cout(Cout), .V(V)
   );

   serial_addsub #(.WIDTH(2)) u2 (
      .clk(clk), .rst(rst2), .start(start2), .M(M2), .A(A2), .B(B2),
      .busy(busy2), .done(done2), .D(D2), .Cout(Cout2), .V(V2)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic reportTimeout(input string name);
      nAssert++;
      nFail++;
      $display("[TB] FAIL %s: no done pulse within the cycle budget (cycle %0d)", name, cycle);
   endtask

   // Reference: plain integer arithmetic, signed range check for overflow.
   function automatic exp_t refModel(input int w, input logic m, input logic [31:0] a, input logic [31:0] b);
      exp_t   r;
      longint mask, al, bl, sum, half, sa, sb, res;
      mask = (64'sd1 <<< w) - 1;
      al   = longint'({32'b0, a}) & mask;
      bl   = longint'({32'b0, b}) & mask;
      sum  = al + (m ? (~bl & mask) : bl) + (m ? 64'sd1 : 64'sd0);
      half = 64'sd1 <<< (w - 1);
      sa   = (al >= half) ? al - (mask + 1) : al;
      sb   = (bl >= half) ? bl - (mask + 1) : bl;
      res  = m ? sa - sb : sa + sb;
      r.d  = 32'(sum & mask);
      r.c  = ((sum >>> w) & 64'sd1) != 0;
      r.v  = (res >= half) || (res < -half);
      r.acceptEdge = 0;
      return r;
   endfunction

   // Called at a falling edge; the operation is accepted on the next rising edge.
   task automatic applyStimulus(input logic m, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] d, input logic c, input logic v);
      exp_t e;
      start = 1'b1; M = m; A = a; B = b;
      e.d = 32'(d); e.c = c; e.v = v; e.acceptEdge = cycle + 1;
      q8.push_back(e);
      @(negedge clk);
      start = 1'b0;
      A = 8'($urandom); B = 8'($urandom); M = 1'($urandom);
      checkOutput("busyAfterAccept", 32'(busy), 32'd1);
   endtask

   task automatic waitDone8(input int maxCycles);
      for (int k = 0; k < maxCycles; k++) begin
         @(negedge clk);
         if (done) return;
      end
      reportTimeout("waitDone8");
   endtask

   task automatic runModel8(input logic m, input logic [7:0] a, input logic [7:0] b);
      exp_t r;
      r = refModel(8, m, 32'(a), 32'(b));
      @(negedge clk);
      applyStimulus(m, a, b, r.d[7:0], r.c, r.v);
      waitDone8(20);
   endtask

   always @(negedge clk) begin : monitor8
      exp_t e;
      if (!rst) begin
         checkOutput("busyDoneExclusive8", 32'(busy & done), 32'd0);
         if (done) begin
            if (q8.size() == 0) begin
               nAssert++;
               nFail++;
               $display("[TB] FAIL unexpectedDone8: got done=1, expected no pulse (cycle %0d)", cycle);
            end else begin
               e = q8.pop_front();
               checkOutput("D8", 32'(D), e.d);
               checkOutput("Cout8", 32'(Cout), 32'(e.c));
               checkOutput("V8", 32'(V), 32'(e.v));
               checkOutput("latency8", 32'(cycle - e.acceptEdge), 32'd8);
            end
         end
      end
   end

   always @(negedge clk) begin : monitor2
      exp_t e;
      if (!rst2) begin
         checkOutput("busyDoneExclusive2", 32'(busy2 & done2), 32'd0);
         if (done2) begin
            if (q2.size() == 0) begin
               nAssert++;
               nFail++;
               $display("[TB] FAIL unexpectedDone2: got done=1, expected no pulse (cycle %0d)", cycle);
            end else begin
               e = q2.pop_front();
               checkOutput("D2", 32'(D2), e.d);
               checkOutput("Cout2", 32'(Cout2), 32'(e.c));
               checkOutput("V2", 32'(V2), 32'(e.v));
               checkOutput("latency2", 32'(cycle - e.acceptEdge), 32'd2);
            end
         end
      end
   end

   initial begin : driver2
      exp_t e;
      bit   got;
      rst2 = 1'b1; start2 = 1'b0; M2 = 1'b0; A2 = '0; B2 = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset2D", 32'(D2), 32'd0);
      rst2 = 1'b0;
      for (int m = 0; m < 2; m++) begin
         for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
               @(negedge clk);
               e = refModel(2, 1'(m), 32'(a), 32'(b));
               e.acceptEdge = cycle + 1;
               q2.push_back(e);
               start2 = 1'b1; M2 = 1'(m); A2 = 2'(a); B2 = 2'(b);
               @(negedge clk);
               start2 = 1'b0; A2 = 2'($urandom); B2 = 2'($urandom);
               got = 1'b0;
               for (int k = 0; k < 10 && !got; k++) begin
                  @(negedge clk);
                  got = done2;
               end
               if (!got) reportTimeout("waitDone2");
            end
         end
      end
      u2Finished = 1'b1;
   end

   initial begin : main
      logic [7:0] corners[4];
      corners = '{8'h00, 8'hFF, 8'h80, 8'h7F};
      rst = 1'b1; start = 1'b0; M = 1'b0; A = '0; B = '0;
      repeat (2) @(negedge clk);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
      checkOutput("resetD", 32'(D), 32'd0);
      checkOutput("resetCout", 32'(Cout), 32'd0);
      checkOutput("resetV", 32'(V), 32'd0);
      rst = 1'b0;

      @(negedge clk);
      applyStimulus(1'b0, 8'd100, 8'd55, 8'h9B, 1'b0, 1'b1);
      waitDone8(20);
      @(negedge clk);
      applyStimulus(1'b0, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0);
      waitDone8(20);

      // Second subtract is issued while the first is in its DONE cycle.
      @(negedge clk);
      applyStimulus(1'b1, 8'd5, 8'd7, 8'hFE, 1'b0, 1'b0);
      waitDone8(20);
      applyStimulus(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
      waitDone8(20);

      // start held through RUN with operands changing: only the accept-edge operands count.
      @(negedge clk);
      begin
         exp_t e;
         start = 1'b1; M = 1'b0; A = 8'h11; B = 8'h22;
         e.d = 32'h33; e.c = 1'b0; e.v = 1'b0; e.acceptEdge = cycle + 1;
         q8.push_back(e);
      end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         A = 8'($urandom); B = 8'($urandom); M = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("noReacceptBusy", 32'(busy), 32'd0);

      // Reset in the 4th RUN cycle aborts and clears the held result.
      @(negedge clk);
      start = 1'b1; M = 1'b0; A = 8'h01; B = 8'h01;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortDone", 32'(done), 32'd0);
      checkOutput("abortD", 32'(D), 32'd0);
      checkOutput("abortCout", 32'(Cout), 32'd0);
      checkOutput("abortV", 32'(V), 32'd0);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      applyStimulus(1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
      waitDone8(20);

      foreach (corners[i]) begin
         foreach (corners[j]) begin
            runModel8(1'b0, corners[i], corners[j]);
            runModel8(1'b1, corners[i], corners[j]);
         end
      end
      for (int n = 0; n < 200; n++) begin
         runModel8(1'($urandom), 8'($urandom), 8'($urandom));
      end

      for (int k = 0; k < 2000 && !u2Finished; k++) @(negedge clk);
      if (!u2Finished) reportTimeout("u2Sweep");
      repeat (4) @(negedge clk);
      checkOutput("queue8Drained", 32'(q8.size()), 32'd0);
      checkOutput("queue2Drained", 32'(q2.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      nAssert++;
      nFail++;
      $display("[TB] FAIL watchdog: simulation time limit reached (cycle %0d)", cycle);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
